// File: rtl/xoodyak_pkg.sv
// Shared constants and FSM state type for the streaming Xoodyak hash controller.
package xoodyak_pkg;
    localparam int STATE_BITS  = 384;
    localparam int STATE_BYTES = STATE_BITS / 8;

    localparam logic [7:0] PAD      = 8'h01;
    localparam logic [7:0] CD_FIRST = 8'h03;
    localparam logic [7:0] CU_SQZ   = 8'h40;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DOWN,
        PERM_REQ,
        PERM_WAIT,
        EMIT,
        SQZ_DOWN
    } hash_state_t;
endpackage

// File: rtl/xoodyak_rate_buf.sv
// Absorb-block byte buffer: bytes land at the write counter, all bytes are visible in parallel.
module xoodyak_rate_buf #(
    parameter int RATE_BYTES = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              i_clr,
    input  logic                              i_wr_en,
    input  logic [7:0]                        i_wr_data,
    output logic [$clog2(RATE_BYTES+1)-1:0]   o_cnt,
    output logic                              o_full,
    output logic [8*RATE_BYTES-1:0]           o_data
);
    localparam int CW = $clog2(RATE_BYTES + 1);

    logic [CW-1:0] r_cnt;
    logic [7:0]    r_buf [RATE_BYTES];
    logic          w_wr;

    assign w_wr   = i_wr_en && !o_full;
    assign o_full = (r_cnt == CW'(RATE_BYTES));
    assign o_cnt  = r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            for (int i = 0; i < RATE_BYTES; i++) r_buf[i] <= 8'h00;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (w_wr) begin
            r_cnt <= r_cnt + CW'(1);
            for (int i = 0; i < RATE_BYTES; i++)
                if (r_cnt == CW'(i)) r_buf[i] <= i_wr_data;
        end
    end

    for (genvar gi = 0; gi < RATE_BYTES; gi++) begin : g_out
        assign o_data[8*gi +: 8] = r_buf[gi];
    end
endmodule

// File: rtl/xoodyak_hash_stream.sv
// Streaming Xoodyak hash controller: absorbs a byte stream, drives an external Xoodoo, squeezes the digest.
// Define XOODYAK_XOF_EN to add the dig_len port for a per-message digest length.
module xoodyak_hash_stream
    import xoodyak_pkg::*;
#(
    parameter int RATE_BYTES   = 16,
    parameter int SQZ_BYTES    = 16,
    parameter int DIGEST_BYTES = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            msg_data,
    input  logic                  msg_valid,
    input  logic                  msg_last,
    input  logic                  msg_empty,
    output logic                  msg_ready,
    output logic                  perm_start,
    output logic [STATE_BITS-1:0] perm_state_out,
    input  logic [STATE_BITS-1:0] perm_state_in,
    input  logic                  perm_done,
    output logic [7:0]            dig_data,
    output logic                  dig_valid,
    output logic                  dig_last,
    input  logic                  dig_ready,
`ifdef XOODYAK_XOF_EN
    input  logic [15:0]           dig_len,
`endif
    output logic                  busy
);
    localparam int CW = $clog2(RATE_BYTES + 1);
    localparam int KW = $clog2(SQZ_BYTES + 1);
    localparam logic [15:0] DIG_DEFAULT = 16'(DIGEST_BYTES);

    hash_state_t           r_fsm;
    logic [STATE_BITS-1:0] r_state;
    logic                  r_first;
    logic                  r_final;
    logic                  r_sqz;
    logic [KW-1:0]         r_k;
    logic [15:0]           r_emitted;
    logic                  r_perm_start;

    logic [CW-1:0]           w_cnt;
    logic                    w_full;
    logic [8*RATE_BYTES-1:0] w_buf_data;
    logic                    w_beat;
    logic                    w_store;
    logic                    w_fill_done;
    logic                    w_blk_end;
    logic                    w_last_byte;
    logic [15:0]             w_dig_total;
    logic [STATE_BITS-1:0]   w_down_state;

`ifdef XOODYAK_XOF_EN
    logic [15:0] r_dig_total;
    assign w_dig_total = r_dig_total;
`else
    assign w_dig_total = DIG_DEFAULT;
`endif

    assign msg_ready   = !reset && ((r_fsm == IDLE) || (r_fsm == FILL && !w_full));
    assign w_beat      = msg_valid && msg_ready;
    assign w_store     = w_beat && !msg_empty;
    assign w_fill_done = w_store && (w_cnt == CW'(RATE_BYTES - 1));
    assign w_blk_end   = msg_last || w_fill_done;
    assign w_last_byte = (r_emitted == w_dig_total - 16'd1);

    assign busy           = (r_fsm != IDLE);
    assign perm_start     = r_perm_start;
    assign perm_state_out = r_state;
    assign dig_valid      = (r_fsm == EMIT);
    assign dig_data       = dig_valid ? r_state[{r_k, 3'b000} +: 8] : 8'h00;
    assign dig_last       = dig_valid && w_last_byte;

    xoodyak_rate_buf #(.RATE_BYTES(RATE_BYTES)) u_rate_buf (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (r_fsm == DOWN),
        .i_wr_en   (w_store),
        .i_wr_data (msg_data),
        .o_cnt     (w_cnt),
        .o_full    (w_full),
        .o_data    (w_buf_data)
    );

    // Down(): message bytes below cnt, pad at cnt, domain bits in the last state byte.
    for (genvar gi = 0; gi < STATE_BYTES; gi++) begin : g_down
        logic [7:0] w_msg;
        logic [7:0] w_pad;
        logic [7:0] w_dom;
        if (gi < RATE_BYTES) begin : g_msg
            assign w_msg = (w_cnt > CW'(gi)) ? w_buf_data[8*gi +: 8] : 8'h00;
        end else begin : g_nomsg
            assign w_msg = 8'h00;
        end
        if (gi <= RATE_BYTES) begin : g_pad
            assign w_pad = (w_cnt == CW'(gi)) ? PAD : 8'h00;
        end else begin : g_nopad
            assign w_pad = 8'h00;
        end
        if (gi == STATE_BYTES - 1) begin : g_dom
            assign w_dom = (r_first ? CD_FIRST : 8'h00) ^ (r_final ? CU_SQZ : 8'h00);
        end else begin : g_nodom
            assign w_dom = 8'h00;
        end
        assign w_down_state[8*gi +: 8] = r_state[8*gi +: 8] ^ w_msg ^ w_pad ^ w_dom;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm        <= IDLE;
            r_state      <= '0;
            r_first      <= 1'b0;
            r_final      <= 1'b0;
            r_sqz        <= 1'b0;
            r_k          <= '0;
            r_emitted    <= '0;
            r_perm_start <= 1'b0;
`ifdef XOODYAK_XOF_EN
            r_dig_total  <= '0;
`endif
        end else begin
            r_perm_start <= 1'b0;
            unique case (r_fsm)
                IDLE: if (w_beat) begin
                    r_state   <= '0;
                    r_first   <= 1'b1;
                    r_sqz     <= 1'b0;
                    r_k       <= '0;
                    r_emitted <= '0;
`ifdef XOODYAK_XOF_EN
                    r_dig_total <= (dig_len == 16'd0) ? DIG_DEFAULT : dig_len;
`endif
                    r_final <= msg_last;
                    r_fsm   <= w_blk_end ? DOWN : FILL;
                end
                FILL: if (w_beat && w_blk_end) begin
                    r_final <= msg_last;
                    r_fsm   <= DOWN;
                end
                DOWN: begin
                    r_state      <= w_down_state;
                    r_first      <= 1'b0;
                    r_sqz        <= r_final;
                    r_perm_start <= 1'b1;
                    r_fsm        <= PERM_REQ;
                end
                PERM_REQ: r_fsm <= PERM_WAIT;
                PERM_WAIT: if (perm_done) begin
                    r_state <= perm_state_in;
                    r_fsm   <= r_sqz ? EMIT : FILL;
                end
                EMIT: if (dig_ready) begin
                    r_emitted <= r_emitted + 16'd1;
                    if (w_last_byte) begin
                        r_fsm <= IDLE;
                    end else begin
                        r_k <= r_k + KW'(1);
                        if (r_k == KW'(SQZ_BYTES - 1)) r_fsm <= SQZ_DOWN;
                    end
                end
                SQZ_DOWN: begin
                    // Down(empty, 0) followed by Up(0)
                    r_state[7:0] <= r_state[7:0] ^ PAD;
                    r_k          <= '0;
                    r_perm_start <= 1'b1;
                    r_fsm        <= PERM_REQ;
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xoodyak_hash_stream.sv
// Randomized bench for xoodyak_hash_stream with a behavioural Xoodoo responder and a Xoodyak hash model.
module tb_xoodyak_hash_stream;
    localparam int RATE   = 16;
    localparam int SQZ    = 16;
    localparam int DIG    = 32;
    localparam int BUDGET = 4000;
    localparam logic [31:0] RC [12] = '{32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
                                        32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012};

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   msg_data;
    logic         msg_valid, msg_last, msg_empty, msg_ready;
    logic         perm_start, perm_done;
    logic [383:0] perm_state_out, perm_state_in;
    logic [7:0]   dig_data;
    logic         dig_valid, dig_last, dig_ready, busy;
`ifdef XOODYAK_XOF_EN
    logic [15:0]  dig_len = 16'd0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]   tx_msg[$];
    logic [7:0]   rx_dig[$];
    logic         rx_last[$];
    logic [383:0] perm_log[$];
    logic [7:0]   ref_dig[$];
    logic [383:0] ref_perm[$];

    always #5 clk = ~clk;

    xoodyak_hash_stream #(.RATE_BYTES(RATE), .SQZ_BYTES(SQZ), .DIGEST_BYTES(DIG)) dut (
        .clk(clk), .reset(reset),
        .msg_data(msg_data), .msg_valid(msg_valid), .msg_last(msg_last), .msg_empty(msg_empty),
        .msg_ready(msg_ready),
        .perm_start(perm_start), .perm_state_out(perm_state_out),
        .perm_state_in(perm_state_in), .perm_done(perm_done),
        .dig_data(dig_data), .dig_valid(dig_valid), .dig_last(dig_last), .dig_ready(dig_ready),
`ifdef XOODYAK_XOF_EN
        .dig_len(dig_len),
`endif
        .busy(busy)
    );

    task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Xoodoo[12] on 12 little-endian 32-bit lanes, lane index x + 4*y.
    function automatic logic [383:0] xoodoo(input logic [383:0] s);
        logic [31:0] a [12];
        logic [31:0] b [12];
        logic [31:0] p [4];
        logic [31:0] e [4];
        logic [383:0] r;
        for (int i = 0; i < 12; i++) a[i] = s[32*i +: 32];
        for (int rnd = 0; rnd < 12; rnd++) begin
            for (int x = 0; x < 4; x++) p[x] = a[x] ^ a[x+4] ^ a[x+8];
            for (int x = 0; x < 4; x++) e[x] = rotl(p[(x+3)%4], 5) ^ rotl(p[(x+3)%4], 14);
            for (int i = 0; i < 12; i++) a[i] = a[i] ^ e[i%4];
            for (int x = 0; x < 4; x++) begin
                b[x]   = a[x];
                b[4+x] = a[4+(x+3)%4];
                b[8+x] = rotl(a[8+x], 11);
            end
            b[0] = b[0] ^ RC[rnd];
            for (int x = 0; x < 4; x++) begin
                a[x]   = b[x]   ^ (~b[4+x] & b[8+x]);
                a[4+x] = b[4+x] ^ (~b[8+x] & b[x]);
                a[8+x] = b[8+x] ^ (~b[x]   & b[4+x]);
            end
            for (int x = 0; x < 4; x++) begin
                b[x]   = a[x];
                b[4+x] = rotl(a[4+x], 1);
                b[8+x] = rotl(a[8+(x+2)%4], 8);
            end
            for (int i = 0; i < 12; i++) a[i] = b[i];
        end
        for (int i = 0; i < 12; i++) r[32*i +: 32] = a[i];
        return r;
    endfunction

    // Xoodyak hash of tx_msg: absorb in RATE-byte blocks, squeeze dlen bytes in SQZ-byte blocks.
    function automatic void ref_hash(input int dlen);
        logic [383:0] st = '0;
        int n = tx_msg.size();
        int pos = 0;
        int blk;
        bit first = 1'b1;
        bit fin;
        ref_perm.delete();
        ref_dig.delete();
        do begin
            blk = (n - pos > RATE) ? RATE : n - pos;
            for (int j = 0; j < blk; j++) st[8*j +: 8] = st[8*j +: 8] ^ tx_msg[pos+j];
            st[8*blk +: 8] = st[8*blk +: 8] ^ 8'h01;
            if (first) st[383:376] = st[383:376] ^ 8'h03;
            first = 1'b0;
            pos += blk;
            fin = (pos == n);
            if (fin) st[383:376] = st[383:376] ^ 8'h40;
            ref_perm.push_back(st);
            st = xoodoo(st);
        end while (!fin);
        while (ref_dig.size() < dlen) begin
            for (int j = 0; j < SQZ && ref_dig.size() < dlen; j++) ref_dig.push_back(st[8*j +: 8]);
            if (ref_dig.size() < dlen) begin
                st[7:0] = st[7:0] ^ 8'h01;
                ref_perm.push_back(st);
                st = xoodoo(st);
            end
        end
    endfunction

    function automatic logic [383:0] perm_at(input int i);
        if (i < perm_log.size()) return perm_log[i];
        return '0;
    endfunction

    // External permutation: answers 3..30 cycles after each perm_start.
    initial begin
        logic [383:0] res;
        int d;
        perm_done = 1'b0;
        perm_state_in = '0;
        forever begin
            @(negedge clk);
            if (perm_start === 1'b1) begin
                perm_log.push_back(perm_state_out);
                res = xoodoo(perm_state_out);
                d = $urandom_range(3, 30);
                repeat (d - 1) @(negedge clk);
                perm_state_in = res;
                perm_done = 1'b1;
                @(negedge clk);
                perm_done = 1'b0;
            end
        end
    end

    task automatic send_msg();
        int n  = tx_msg.size();
        int nb = (n == 0) ? 1 : n;
        int i  = 0;
        int t  = 0;
        bit rdy_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (msg_valid && rdy_seen) i++;
            if (i >= nb || t > BUDGET) break;
            msg_valid = ($urandom_range(0, 3) != 0);
            msg_data  = (n == 0) ? 8'h00 : tx_msg[i];
            msg_last  = (i == nb - 1);
            msg_empty = (n == 0);
            rdy_seen  = msg_ready;
            t++;
        end
        msg_valid = 1'b0;
        msg_last  = 1'b0;
        msg_empty = 1'b0;
        check("msg_beats_accepted", i, nb);
    endtask

    task automatic recv_dig(input int dlen);
        int stall = $urandom_range(0, 5);
        int t = 0;
        bit held = 1'b0;
        logic [7:0] held_data = 8'h00;
        rx_dig.delete();
        rx_last.delete();
        forever begin
            @(negedge clk);
            if (held) begin
                check("stall_valid", dig_valid, 1'b1);
                check("stall_data", dig_data, held_data);
            end
            held = 1'b0;
            if (rx_dig.size() >= dlen || t > BUDGET) break;
            t++;
            if (dig_valid) begin
                if (stall > 0) begin
                    dig_ready = 1'b0;
                    stall--;
                    held = 1'b1;
                    held_data = dig_data;
                end else begin
                    dig_ready = 1'b1;
                    rx_dig.push_back(dig_data);
                    rx_last.push_back(dig_last);
                    stall = $urandom_range(0, 5);
                end
            end else begin
                dig_ready = 1'($urandom_range(0, 1));
            end
        end
        dig_ready = 1'b0;
        check("busy_after_last", busy, 1'b0);
    endtask

    task automatic run_hash(input string tag, input int req_len);
        int eff;
`ifdef XOODYAK_XOF_EN
        dig_len = 16'(req_len);
        eff = (req_len == 0) ? DIG : req_len;
`else
        eff = (req_len < 0) ? 0 : DIG;
`endif
        perm_log.delete();
        ref_hash(eff);
        fork
            send_msg();
            recv_dig(eff);
        join
        check({tag, "_nbytes"}, rx_dig.size(), eff);
        for (int i = 0; i < rx_dig.size() && i < eff; i++) begin
            check({tag, "_byte"}, rx_dig[i], ref_dig[i]);
            check({tag, "_last"}, rx_last[i], (i == eff - 1));
        end
        check({tag, "_nperm"}, perm_log.size(), ref_perm.size());
        for (int i = 0; i < perm_log.size() && i < ref_perm.size(); i++)
            check({tag, "_perm_in"}, perm_log[i], ref_perm[i]);
        $display("hash %s: len=%0d digest=%0d bytes perms=%0d", tag, tx_msg.size(), rx_dig.size(), perm_log.size());
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [383:0] e;
        logic [383:0] p0;
        logic [383:0] p1;
        reset = 1'b1;
        msg_data = 8'h00; msg_valid = 1'b0; msg_last = 1'b0; msg_empty = 1'b0;
        dig_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_msg_ready", msg_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_dig_valid", dig_valid, 1'b0);
        check("rst_perm_start", perm_start, 1'b0);
        check("rst_perm_state", perm_state_out, '0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_msg_ready", msg_ready, 1'b1);

        tx_msg.delete();
        run_hash("empty", 0);
        e = '0; e[7:0] = 8'h01; e[383:376] = 8'h43;
        check("empty_perm0", perm_at(0), e);
        check("empty_nperm", perm_log.size(), 2);

        tx_msg = '{8'h61, 8'h62, 8'h63};
        run_hash("abc", 0);
        e = '0; e[31:0] = 32'h01636261; e[383:376] = 8'h43;
        check("abc_perm0", perm_at(0), e);

        tx_msg.delete();
        for (int j = 0; j < 16; j++) tx_msg.push_back(8'($urandom));
        run_hash("len16", 0);
        e = '0;
        for (int j = 0; j < 16; j++) e[8*j +: 8] = tx_msg[j];
        e[135:128] = 8'h01; e[383:376] = 8'h43;
        check("len16_perm0", perm_at(0), e);

        tx_msg.delete();
        for (int j = 0; j < 17; j++) tx_msg.push_back(8'($urandom));
        run_hash("len17", 0);
        p0 = perm_at(0);
        p1 = perm_at(1);
        check("len17_p0_dom", p0[383:376], 8'h03);
        e = '0;
        for (int j = 0; j < 16; j++) e[8*j +: 8] = tx_msg[j];
        e[135:128] = 8'h01; e[383:376] = 8'h03;
        check("len17_perm0", p0, e);
        e = '0; e[7:0] = tx_msg[16]; e[15:8] = 8'h01; e[383:376] = 8'h40;
        check("len17_perm1_delta", p1 ^ xoodoo(p0), e);

        for (int k = 0; k < 6; k++) begin
            int len = $urandom_range(0, 50);
            tx_msg.delete();
            for (int j = 0; j < len; j++) tx_msg.push_back(8'($urandom));
            run_hash("rnd", $urandom_range(0, 48));
        end

        // Reset while the absorb permutation is pending; its late perm_done must be ignored.
        tx_msg = '{8'h61, 8'h62, 8'h63};
        perm_log.delete();
        send_msg();
        for (int w = 0; w < 100 && perm_log.size() == 0; w++) @(negedge clk);
        check("rst_reached_perm", perm_log.size() > 0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (35) @(negedge clk);
        check("late_busy", busy, 1'b0);
        check("late_dig_valid", dig_valid, 1'b0);
        check("late_perm_start", perm_start, 1'b0);
        check("late_perm_state", perm_state_out, '0);
        check("late_msg_ready", msg_ready, 1'b1);
        run_hash("abc_after_rst", 0);

`ifdef XOODYAK_XOF_EN
        tx_msg.delete();
        run_hash("xof40", 40);
        check("xof40_nperm", perm_log.size(), 3);
        tx_msg = '{8'h61, 8'h62, 8'h63};
        run_hash("xof0", 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
